// File: rtl/vip_genlock_phase_compare.sv
// rtl/vip_genlock_phase_compare.sv - genlock phase comparator: selected reference SOF vs local SOF, correction decision
// Build macro VIP_GENLOCK_RETIME_EN adds two output register stages (latency E+4 instead of E+2).
module vip_genlock_phase_compare #(
  parameter int H_WIDTH     = 14,
  parameter int V_WIDTH     = 13,
  parameter int NUM_REFS    = 2,
  parameter int SEL_WIDTH   = 1,
  parameter int TOLERANCE   = 2,
  parameter int LOCK_FRAMES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_genlock_en,
  input  logic                 i_restart,
  input  logic [SEL_WIDTH-1:0] i_ref_select,
  input  logic [H_WIDTH-1:0]   i_h_total_minus_one,
  input  logic [H_WIDTH-1:0]   i_sample_threshold,
  input  logic [NUM_REFS-1:0]  i_sof_ref,
  input  logic [NUM_REFS-1:0]  i_ref_locked,
  input  logic                 i_sof_local,
  input  logic                 i_local_locked,
  output logic                 o_sync_lines,
  output logic                 o_sync_samples,
  output logic                 o_remove_repeatn,
  output logic [H_WIDTH-1:0]   o_h_reset,
  output logic [V_WIDTH-1:0]   o_v_reset,
  output logic                 o_genlocked
);
  localparam int OUT_W = 4 + H_WIDTH + V_WIDTH;
  localparam logic [H_WIDTH-1:0] TOL = H_WIDTH'(TOLERANCE);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_REF_LEAD, S_LOC_LEAD} state_t;
  state_t r_state, w_state_nxt;

  logic                 w_ref_lvl, w_ref_lk, r_ref_prev, r_loc_prev;
  logic [SEL_WIDTH-1:0] r_sel_prev;
  logic                 w_ref_edge, w_loc_edge, w_sclr;
  logic [H_WIDTH-1:0]   r_h, w_h_nxt;
  logic [V_WIDTH-1:0]   r_v, w_v_nxt;
  logic                 w_h_wrap;
  logic                 w_cap_rem, w_cap_rep, w_cap_both, w_cap_any, w_consistent;
  logic [H_WIDTH-1:0]   r_rem_h, r_rep_h;
  logic [V_WIDTH-1:0]   r_rem_v, r_rep_v;
  logic [3:0]           r_stable;
  logic                 w_valid, w_remove;
  logic [V_WIDTH+H_WIDTH-1:0] w_off;
  logic [OUT_W-1:0]     w_dec, r_dec, w_out;

  always_comb begin
    w_ref_lvl = 1'b0;
    w_ref_lk  = 1'b0;
    for (int i = 0; i < NUM_REFS; i++) begin
      if (i_ref_select == SEL_WIDTH'(i)) begin
        w_ref_lvl = i_sof_ref[i];
        w_ref_lk  = i_ref_locked[i];
      end
    end
  end

  assign w_ref_edge = w_ref_lvl & ~r_ref_prev;
  assign w_loc_edge = i_sof_local & ~r_loc_prev;
  assign w_sclr = ~(i_genlock_en & i_local_locked & w_ref_lk) | i_restart | (i_ref_select != r_sel_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_prev <= 1'b0;
      r_loc_prev <= 1'b0;
      r_sel_prev <= '0;
    end else begin
      r_ref_prev <= w_ref_lvl;
      r_loc_prev <= i_sof_local;
      r_sel_prev <= i_ref_select;
    end
  end

  // Captures take the post-increment count so a gap of N cycles measures as N samples.
  assign w_h_wrap = (r_h == i_h_total_minus_one);
  assign w_h_nxt  = w_h_wrap ? '0 : r_h + 1'b1;
  assign w_v_nxt  = (w_h_wrap && r_v != '1) ? r_v + 1'b1 : r_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_sclr || w_ref_edge || w_loc_edge) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_nxt;
      r_v <= w_v_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_sclr || (w_ref_edge && w_loc_edge)) w_state_nxt = S_IDLE;
    else if (w_loc_edge)                      w_state_nxt = S_LOC_LEAD;
    else if (w_ref_edge)                      w_state_nxt = S_REF_LEAD;
  end

  always_comb begin
    w_cap_rem  = 1'b0;
    w_cap_rep  = 1'b0;
    w_cap_both = 1'b0;
    if (!w_sclr) begin
      if (w_ref_edge && w_loc_edge)                    w_cap_both = 1'b1;
      else if (w_loc_edge && r_state == S_REF_LEAD)    w_cap_rem  = 1'b1;
      else if (w_ref_edge && r_state == S_LOC_LEAD)    w_cap_rep  = 1'b1;
    end
  end

  function automatic logic f_close(input logic [V_WIDTH-1:0] v_new, input logic [H_WIDTH-1:0] h_new,
                                   input logic [V_WIDTH-1:0] v_old, input logic [H_WIDTH-1:0] h_old);
    logic [H_WIDTH-1:0] dh;
    dh = (h_new >= h_old) ? h_new - h_old : h_old - h_new;
    return (v_new == v_old) && (dh <= TOL);
  endfunction

  assign w_cap_any = w_cap_rem | w_cap_rep | w_cap_both;
  assign w_consistent = w_cap_both ? (f_close('0, '0, r_rem_v, r_rem_h) && f_close('0, '0, r_rep_v, r_rep_h)) :
                        w_cap_rem  ? f_close(w_v_nxt, w_h_nxt, r_rem_v, r_rem_h) :
                                     f_close(w_v_nxt, w_h_nxt, r_rep_v, r_rep_h);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem_v <= '0; r_rem_h <= '0; r_rep_v <= '0; r_rep_h <= '0;
    end else if (w_sclr || w_cap_both) begin
      r_rem_v <= '0; r_rem_h <= '0; r_rep_v <= '0; r_rep_h <= '0;
    end else if (w_cap_rem) begin
      r_rem_v <= w_v_nxt; r_rem_h <= w_h_nxt;
    end else if (w_cap_rep) begin
      r_rep_v <= w_v_nxt; r_rep_h <= w_h_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_stable <= '0;
    else if (w_sclr)    r_stable <= '0;
    else if (w_cap_any) r_stable <= !w_consistent ? 4'd0 : (r_stable == 4'hf) ? r_stable : r_stable + 4'd1;
  end

  assign w_valid  = (r_stable >= LOCK_N);
  assign w_remove = {r_rem_v, r_rem_h} < {r_rep_v, r_rep_h};
  assign w_off    = w_remove ? {r_rem_v, r_rem_h} : {r_rep_v, r_rep_h};

  // Packed as {sync_lines, sync_samples, remove_repeatn, genlocked, v_reset, h_reset}.
  always_comb begin
    w_dec = '0;
    w_dec[OUT_W-3] = w_remove;
    if (w_valid) begin
      if (w_off[H_WIDTH +: V_WIDTH] != '0) begin
        w_dec[OUT_W-1] = 1'b1;
        w_dec[OUT_W-2] = 1'b1;
        w_dec[V_WIDTH+H_WIDTH-1:0] = w_off;
      end else if (w_off[H_WIDTH-1:0] > i_sample_threshold) begin
        w_dec[OUT_W-2] = 1'b1;
        w_dec[H_WIDTH-1:0] = w_off[H_WIDTH-1:0];
      end else begin
        w_dec[OUT_W-4] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dec <= '0;
    else     r_dec <= w_dec;
  end

`ifdef VIP_GENLOCK_RETIME_EN
  logic [OUT_W-1:0] r_rt1, r_rt2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rt1 <= '0;
      r_rt2 <= '0;
    end else begin
      r_rt1 <= r_dec;
      r_rt2 <= r_rt1;
    end
  end
  assign w_out = r_rt2;
`else
  assign w_out = r_dec;
`endif

  assign {o_sync_lines, o_sync_samples, o_remove_repeatn, o_genlocked, o_v_reset, o_h_reset} = w_out;
endmodule
